// File: rtl/hp_add_subtract.sv
// Registered floating-point adder (1/NEXP/NSIG format, bfloat16 by default).
// Single-cycle combinational datapath feeding one output register stage.
module hp_add_subtract #(
  parameter int NEXP        = 8,
  parameter int NSIG        = 7,
  parameter int NTYPES      = 6,
  parameter int NEXCEPTIONS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  output logic [NEXP+NSIG:0]     result,
  output logic [NTYPES-1:0]      bfFlags,
  output logic [NEXCEPTIONS-1:0] exception
);
  localparam int W  = NEXP + NSIG + 1;
  localparam int M  = NSIG + 4;   // hidden + fraction + guard/round/sticky
  localparam int EW = NEXP + 2;
  localparam logic [NEXP-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  logic            w_sa, w_sb;
  logic [NEXP-1:0] w_ea, w_eb;
  logic [NSIG-1:0] w_fa, w_fb;
  logic            w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic            w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic            w_swap, w_sl, w_ss;
  logic [EW-1:0]   w_el, w_es, w_diff, w_dsh, w_lz, w_lsh, w_en, w_ef;
  logic [NSIG:0]   w_ml, w_ms, w_mf;
  logic [2*M-1:0]  w_wide;
  logic [M-1:0]    w_lg, w_sm, w_norm;
  logic [M:0]      w_sum;
  logic            w_rnd, w_inx, w_ovf;
  logic [NSIG+1:0] w_mr;
  logic [W-1:0]    w_res;
  logic [NEXCEPTIONS-1:0] w_exc;

  logic [W-1:0]           r_result;
  logic [NTYPES-1:0]      r_flags;
  logic [NEXCEPTIONS-1:0] r_exc;

  assign {w_sa, w_ea, w_fa} = a;
  assign {w_sb, w_eb, w_fb} = b;

  assign w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_snan = w_a_nan && !w_fa[NSIG-1];
  assign w_b_snan = w_b_nan && !w_fb[NSIG-1];
  assign w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EMAX) && (w_fb == '0);
  assign w_a_zero = (w_ea == '0) && (w_fa == '0);
  assign w_b_zero = (w_eb == '0) && (w_fb == '0);

  // Larger magnitude goes first; raw {exp,frac} ordering matches magnitude order.
  assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_sl   = w_swap ? w_sb : w_sa;
  assign w_ss   = w_swap ? w_sa : w_sb;
  assign w_el   = w_swap ? ((w_eb == '0) ? EW'(1) : EW'(w_eb)) : ((w_ea == '0) ? EW'(1) : EW'(w_ea));
  assign w_es   = w_swap ? ((w_ea == '0) ? EW'(1) : EW'(w_ea)) : ((w_eb == '0) ? EW'(1) : EW'(w_eb));
  assign w_ml   = w_swap ? {|w_eb, w_fb} : {|w_ea, w_fa};
  assign w_ms   = w_swap ? {|w_ea, w_fa} : {|w_eb, w_fb};

  function automatic logic [NTYPES-1:0] classify(input logic [W-1:0] v);
    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    e = v[W-2:NSIG];
    f = v[NSIG-1:0];
    classify = '0;
    if (e == EMAX) begin
      if (f == '0)          classify[3] = 1'b1;
      else if (f[NSIG-1])   classify[4] = 1'b1;
      else                  classify[5] = 1'b1;
    end else if (e == '0) begin
      if (f == '0) classify[2] = 1'b1;
      else         classify[1] = 1'b1;
    end else begin
      classify[0] = 1'b1;
    end
  endfunction

  always_comb begin
    // Alignment: bits shifted below the window all fold into sticky.
    w_diff = w_el - w_es;
    w_dsh  = (w_diff > EW'(M)) ? EW'(M) : w_diff;
    w_wide = {w_ms, 3'b000, {M{1'b0}}} >> w_dsh;
    w_sm   = {w_wide[2*M-1:M+1], w_wide[M] | (|w_wide[M-1:0])};
    w_lg   = {w_ml, 3'b000};
    w_sum  = (w_sl == w_ss) ? ({1'b0, w_lg} + {1'b0, w_sm}) : ({1'b0, w_lg} - {1'b0, w_sm});

    w_lz = EW'(M);
    for (int i = 0; i < M; i++)
      if (w_sum[i]) w_lz = EW'(M - 1 - i);

    // Left shift is capped so the exponent never drops below 1 (subnormal boundary).
    w_lsh = '0;
    if (w_sum[M]) begin
      w_norm = {w_sum[M:2], w_sum[1] | w_sum[0]};
      w_en   = w_el + EW'(1);
    end else begin
      w_lsh  = (w_lz < w_el - EW'(1)) ? w_lz : w_el - EW'(1);
      w_norm = w_sum[M-1:0] << w_lsh;
      w_en   = w_el - w_lsh;
    end

    w_rnd = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_inx = |w_norm[2:0];
    w_mr  = {1'b0, w_norm[M-1:3]} + (NSIG+2)'(w_rnd);
    if (w_mr[NSIG+1]) begin
      w_mf = w_mr[NSIG+1:1];
      w_ef = w_en + EW'(1);
    end else begin
      w_mf = w_mr[NSIG:0];
      w_ef = w_en;
    end
    w_ovf = w_mf[NSIG] && (w_ef >= {2'b00, EMAX});

    w_res = '0;
    w_exc = '0;
    if (w_a_nan || w_b_nan) begin
      w_res    = QNAN;
      w_exc[4] = w_a_snan | w_b_snan;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_res    = QNAN;
      w_exc[4] = 1'b1;
    end else if (w_a_inf) begin
      w_res = a;
    end else if (w_b_inf) begin
      w_res = b;
    end else if (w_a_zero && w_b_zero) begin
      w_res = {w_sa & w_sb, {(W-1){1'b0}}};
    end else if (w_b_zero) begin
      w_res = a;
    end else if (w_a_zero) begin
      w_res = b;
    end else if (w_sum == '0) begin
      w_res = '0;
    end else if (w_ovf) begin
      w_res    = {w_sl, EMAX, {NSIG{1'b0}}};
      w_exc[2] = 1'b1;
      w_exc[0] = 1'b1;
    end else begin
      w_res    = {w_sl, (w_mf[NSIG] ? w_ef[NEXP-1:0] : {NEXP{1'b0}}), w_mf[NSIG-1:0]};
      w_exc[0] = w_inx;
      w_exc[1] = w_inx & ~w_mf[NSIG];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
      r_exc    <= '0;
    end else begin
      r_result <= w_res;
      r_flags  <= classify(w_res);
      r_exc    <= w_exc;
    end
  end

  assign result    = r_result;
  assign bfFlags   = r_flags;
  assign exception = r_exc;
endmodule

// File: tb/tb_hp_add_subtract.sv
// Directed-vector bench for the bfloat16 adder; expected values hand-computed.
module tb_hp_add_subtract;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b, result;
  logic [5:0]  bfFlags;
  logic [4:0]  exception;
  int total = 0, bad = 0;

  localparam logic [5:0] NRM = 6'b000001, SUB = 6'b000010, ZER = 6'b000100,
                         INF = 6'b001000, QNN = 6'b010000;

  always #5 clk = ~clk;

  hp_add_subtract dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .result(result), .bfFlags(bfFlags), .exception(exception)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic [15:0] er, input logic [5:0] ef, input logic [4:0] ee);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, 32'(result), 32'(er));
    chk({tag, ".cls"}, 32'(bfFlags), 32'(ef));
    chk({tag, ".exc"}, 32'(exception), 32'(ee));
  endtask

  initial begin
    reset = 1'b1;
    a = 16'h4000;
    b = 16'h4040;
    @(posedge clk);
    #1;
    chk("rst.res", 32'(result), 32'h0);
    chk("rst.cls", 32'(bfFlags), 32'h0);
    chk("rst.exc", 32'(exception), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    vec("add2p3",   16'h4000, 16'h4040, 16'h40A0, NRM, 5'b00000);
    vec("4m2",      16'h4080, 16'hC000, 16'h4000, NRM, 5'b00000);
    vec("2m4",      16'h4000, 16'hC080, 16'hC000, NRM, 5'b00000);
    vec("m4m2",     16'hC080, 16'hC000, 16'hC0C0, NRM, 5'b00000);
    vec("zz",       16'h0000, 16'h0000, 16'h0000, ZER, 5'b00000);
    vec("pzmz",     16'h0000, 16'h8000, 16'h0000, ZER, 5'b00000);
    vec("mzpz",     16'h8000, 16'h0000, 16'h0000, ZER, 5'b00000);
    vec("mzmz",     16'h8000, 16'h8000, 16'h8000, ZER, 5'b00000);
    vec("xmz",      16'h4040, 16'h8000, 16'h4040, NRM, 5'b00000);
    vec("inf",      16'h7F80, 16'h4000, 16'h7F80, INF, 5'b00000);
    vec("infmi",    16'h7F80, 16'hFF80, 16'h7FC0, QNN, 5'b10000);
    vec("snan",     16'h7F81, 16'h4000, 16'h7FC0, QNN, 5'b10000);
    vec("qnan",     16'h4000, 16'h7FC1, 16'h7FC0, QNN, 5'b00000);
    vec("ovf",      16'h7F7F, 16'h7F7F, 16'h7F80, INF, 5'b00101);
    vec("sticky",   16'h3F80, 16'h3380, 16'h3F80, NRM, 5'b00001);
    vec("tie_even", 16'h3F80, 16'h3B80, 16'h3F80, NRM, 5'b00001);
    vec("tie_odd",  16'h3F81, 16'h3B80, 16'h3F82, NRM, 5'b00001);
    vec("cancel",   16'h3F80, 16'hBF80, 16'h0000, ZER, 5'b00000);
    vec("subsub",   16'h0001, 16'h0001, 16'h0002, SUB, 5'b00000);
    vec("sub2nrm",  16'h0040, 16'h0040, 16'h0080, NRM, 5'b00000);

    // Reset mid-stream with live operands on the bus.
    @(negedge clk);
    reset = 1'b1;
    a = 16'h4040;
    b = 16'h4040;
    @(posedge clk);
    #1;
    chk("midrst.res", 32'(result), 32'h0);
    chk("midrst.cls", 32'(bfFlags), 32'h0);
    chk("midrst.exc", 32'(exception), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst.res", 32'(result), 32'h40C0);
    chk("postrst.cls", 32'(bfFlags), 32'(NRM));
    vec("after", 16'h4000, 16'h4040, 16'h40A0, NRM, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hp_add_subtract.md
Name: hp_add_subtract

Overview:
- Registered floating-point adder for a parameterised binary format: 1 sign bit, NEXP exponent bits, NSIG stored fraction bits. The default is bfloat16 (8/7).
- Computes a + b. Subtraction is performed by the caller flipping the sign bit of b.
- Also outputs a one-hot class of the result and the IEEE-754 exception flags.
- It is the add/sub datapath of the float processing unit. It shares the class/exception encodings used by the other FPU blocks.

Parameters:
- NEXP, 8, exponent width; bias = 2^(NEXP-1)-1.
- NSIG, 7, stored fraction width; the hidden bit is implicit.
- NTYPES, 6, number of class flags (fixed by the shared class encoding).
- NEXCEPTIONS, 5, number of exception flags (fixed by the shared class encoding).

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- a  in  NEXP+NSIG+1  operand A: {sign, exp, frac}.
- b  in  NEXP+NSIG+1  operand B: same layout as a.
- result  out  NEXP+NSIG+1  registered sum.
- bfFlags  out  NTYPES  one-hot class of result.
  - bit5 SNAN, bit4 QNAN, bit3 INFINITY, bit2 ZERO, bit1 SUBNORMAL, bit0 NORMAL.
- exception  out  NEXCEPTIONS  exception flags.
  - bit4 INVALID, bit3 DIVBYZERO (always 0), bit2 OVERFLOW, bit1 UNDERFLOW, bit0 INEXACT.

Behaviour:
- Reset: on a clk edge with reset=1, result, bfFlags and exception all become 0. Reset has priority over any in-flight computation; no partial result survives it.
- Timing:
  - a and b are sampled on each rising clk edge with reset=0.
  - The corresponding result, bfFlags and exception are valid after that same edge, i.e. 1-cycle latency.
  - Fully pipelined: a new operand pair is accepted every cycle. There is no handshake.
- Input classes:
  - exp all-ones with frac 0 is infinity.
  - exp all-ones with frac nonzero is NaN; frac MSB=1 is quiet, frac MSB=0 is signalling.
  - exp 0 with frac 0 is zero.
  - exp 0 with frac nonzero is subnormal, with effective exponent 1 and hidden bit 0.
- Special cases, checked in priority order:
  - Any input NaN: result = canonical qNaN {0, all-ones, 1 followed by zeros} (0x7FC0 by default). INVALID is set if either input is an sNaN.
  - +inf + -inf: canonical qNaN, INVALID=1.
  - inf + finite, or inf + inf of the same sign: that infinity, no flags.
  - x + (±0): x exactly.
  - +0 + -0: +0.
  - -0 + -0: -0.
- Datapath:
  - Swap operands so the larger magnitude (exp, then frac) is first.
  - Align the smaller operand by the exponent difference, keeping guard, round and sticky bits. A shift of NSIG+3 or more collapses the smaller operand into sticky.
  - Add the significands if the signs match, otherwise subtract. The result sign is the sign of the larger-magnitude operand.
  - Normalise: right-shift by 1 on carry-out; left-shift by the leading-zero count on cancellation, stopping at the subnormal boundary.
  - Round to nearest, ties to even. If rounding carries out, renormalise and increment the exponent.
  - Exact cancellation (equal magnitudes, opposite signs) gives +0 with no flags.
- Flags:
  - INEXACT: any guard, round or sticky bit was lost.
  - OVERFLOW: the rounded exponent is at or above all-ones. result = ±inf, and INEXACT is also set.
  - UNDERFLOW: the result is tiny after rounding (subnormal or zero from a nonzero sum) and inexact.
  - bfFlags classifies the final result; exactly one bit is set whenever reset is not active.
- Implementation is fully synchronous with a single output register stage; all logic before it is combinational.

Test Plan:
- a=0x4000 (2.0), b=0x4040 (3.0) -> next cycle result=0x40A0 (5.0), bfFlags=000001, exception=00000.
- a=0x4080 (4.0), b=0xC000 (-2.0) -> result=0x4000 (2.0), flags NORMAL; a=0x4000, b=0xC080 -> result=0xC000 (-2.0).
- a=0xC080 (-4.0), b=0xC000 (-2.0) -> result=0xC0C0 (-6.0); a=0x0000, b=0x0000 -> result=0x0000, bfFlags=000100.
- a=0x7F80 (+inf), b=0x4000 -> result=0x7F80, bfFlags=001000, exception=0. a=0x7F81 (sNaN), b=0x4000 -> result=0x7FC0, bfFlags=010000, exception=10000.
- Overflow/rounding: 0x7F7F+0x7F7F -> 0x7F80 with exception=00101. 0x3F80+0x3380 (1.0 + 2^-24) -> 0x3F80 with INEXACT=1. 0x3F80+0xBF80 -> 0x0000.
- Assert reset for one cycle mid-stream -> all outputs 0 after that edge; the next operands give a correct result one cycle after reset drops.
